// File: rtl/data_write_sync.sv
// data_write_sync: bridge between a byte-addressed CPU data port and a
// 32-bit word-addressed data memory.
// - Reads and word writes pass straight through in one cycle.
// - A byte or halfword write is a two-cycle read-modify-write:
//     1. Read the target word from memory.
//     2. Write back the merged word while busy is high.
module data_write_sync (
    input  logic        clk,
    input  logic        rst_n,
    inout  wire  [31:0] data_bus_i,
    input  logic [31:0] data_address_i,
    input  logic        data_cs_i,
    input  logic        data_rw_i,
    input  logic [1:0]  data_mode,
    inout  wire  [31:0] data_bus_o,
    output logic [29:0] data_address_o,
    output logic        data_cs_o,
    output logic        data_rw_o,
    output logic        busy
);

    typedef enum logic {
        IDLE       = 1'b0,
        WRITE_BACK = 1'b1
    } state_t;

    state_t      state_reg;
    state_t      state_next;

    // Context captured during the read phase of a sub-word write
    logic [29:0] addr_reg;
    logic        half_reg;      // 1 = halfword access, 0 = byte access
    logic [1:0]  offset_reg;
    logic [15:0] wdata_reg;
    logic [31:0] word_reg;

    logic        start_rmw;
    logic [31:0] merged_word;
    logic [31:0] read_data;
    logic [31:0] mem_wdata;
    logic        cpu_rd_en;

    // A sub-word write in IDLE starts the read-modify-write sequence.
    // Mode 2 and mode 3 are both full-word accesses.
    assign start_rmw = (state_reg == IDLE) && data_cs_i && data_rw_i && !data_mode[1];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: WRITE_BACK always lasts exactly one cycle
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:       if (start_rmw) state_next = WRITE_BACK;
            WRITE_BACK: state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    // Capture address, size, lane, write data and the current memory word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg   <= '0;
            half_reg   <= 1'b0;
            offset_reg <= '0;
            wdata_reg  <= '0;
            word_reg   <= '0;
        end else if (start_rmw) begin
            addr_reg   <= data_address_i[31:2];
            half_reg   <= data_mode[0];
            offset_reg <= data_address_i[1:0];
            wdata_reg  <= data_bus_i[15:0];
            word_reg   <= data_bus_o;
        end
    end

    // Build the write-back word one byte lane at a time:
    // - A halfword covers the lane pair selected by offset bit 1.
    // - A byte covers only the lane selected by the full offset.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam logic [1:0] LANE = 2'(gi);
        logic       lane_hit;
        logic [7:0] lane_src;

        assign lane_hit = half_reg ? (offset_reg[1] == LANE[1]) : (offset_reg == LANE);
        assign lane_src = half_reg ? wdata_reg[8*(gi%2) +: 8] : wdata_reg[7:0];
        assign merged_word[8*gi +: 8] = lane_hit ? lane_src : word_reg[8*gi +: 8];
    end

    // Extract the addressed lane of the memory word for CPU reads.
    // The lane is zero-extended and right-aligned.
    always_comb begin
        read_data = data_bus_o;
        case (data_mode)
            2'd0:    read_data = {24'b0, data_bus_o[{data_address_i[1:0], 3'b000} +: 8]};
            2'd1:    read_data = {16'b0, data_bus_o[{data_address_i[1], 4'b0000} +: 16]};
            default: read_data = data_bus_o;
        endcase
    end

    // Memory-side controls and bus enables.
    // Everything is forced idle while reset is held, so a write-back that
    // is in flight is abandoned immediately.
    always_comb begin
        data_cs_o      = 1'b0;
        data_rw_o      = 1'b0;
        busy           = 1'b0;
        data_address_o = data_address_i[31:2];
        mem_wdata      = data_bus_i;
        cpu_rd_en      = 1'b0;
        if (rst_n) begin
            case (state_reg)
                IDLE: begin
                    if (data_cs_i) begin
                        data_cs_o = 1'b1;
                        if (data_rw_i) begin
                            // Word writes go straight out.
                            // Sub-word writes read the memory word first.
                            data_rw_o = data_mode[1];
                        end else begin
                            cpu_rd_en = 1'b1;
                        end
                    end
                end
                WRITE_BACK: begin
                    data_cs_o      = 1'b1;
                    data_rw_o      = 1'b1;
                    busy           = 1'b1;
                    data_address_o = addr_reg;
                    mem_wdata      = merged_word;
                end
                default: ;
            endcase
        end
    end

    assign data_bus_o = (data_cs_o && data_rw_o) ? mem_wdata : 32'bz;
    assign data_bus_i = cpu_rd_en ? read_data : 32'bz;

endmodule

// File: tb/tb_data_write_sync.sv
// Testbench for data_write_sync.
// - A small memory sits on the memory side of the bridge.
// - A transaction-level model tracks the expected memory contents and the
//   pending write-back.
// - Directed vectors use hand-computed values.
module tb_data_write_sync;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        mem_clr   = 1'b1;
    logic [31:0] cpu_addr  = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_cs    = 1'b0;
    logic        cpu_rw    = 1'b0;
    logic [1:0]  cpu_mode  = '0;

    wire  [31:0] cpu_bus;
    wire  [31:0] mem_bus;
    wire  [29:0] mem_addr;
    wire         mem_cs;
    wire         mem_rw;
    wire         busy;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] mem  [0:15];
    logic [31:0] gold [0:15];

    // Model state for a pending write-back
    logic        m_wb   = 1'b0;
    logic [29:0] m_addr = '0;
    logic [31:0] m_word = '0;

    always #5 clk = ~clk;

    data_write_sync dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_bus_i     (cpu_bus),
        .data_address_i (cpu_addr),
        .data_cs_i      (cpu_cs),
        .data_rw_i      (cpu_rw),
        .data_mode      (cpu_mode),
        .data_bus_o     (mem_bus),
        .data_address_o (mem_addr),
        .data_cs_o      (mem_cs),
        .data_rw_o      (mem_rw),
        .busy           (busy)
    );

    // CPU drives its bus on writes
    assign cpu_bus = (cpu_cs && cpu_rw) ? cpu_wdata : 32'bz;

    // Memory returns read data combinationally
    assign mem_bus = (mem_cs && !mem_rw) ? mem[mem_addr[3:0]] : 32'bz;

    // Memory commits writes on the rising edge
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else if (mem_cs && mem_rw) begin
            mem[mem_addr[3:0]] <= mem_bus;
        end
    end

    function automatic logic [4:0] lane_shift(input logic [1:0] mode, input logic [31:0] addr);
        if (mode == 2'd0) return {addr[1:0], 3'b000};
        if (mode == 2'd1) return {addr[1], 4'b0000};
        return 5'd0;
    endfunction

    function automatic logic [31:0] lane_mask(input logic [1:0] mode, input logic [31:0] addr);
        if (mode == 2'd0) return 32'h0000_00FF << lane_shift(mode, addr);
        if (mode == 2'd1) return 32'h0000_FFFF << lane_shift(mode, addr);
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] read_lane(input logic [31:0] word, input logic [1:0] mode,
                                              input logic [31:0] addr);
        return (word & lane_mask(mode, addr)) >> lane_shift(mode, addr);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [1:0] mode, input logic [31:0] addr);
        return (old & ~lane_mask(mode, addr)) | ((data << lane_shift(mode, addr)) & lane_mask(mode, addr));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model:
    // - A word write lands at the edge.
    // - A sub-word write lands one edge later, unless reset cuts it off.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_wb <= 1'b0;
            if (mem_clr) begin
                for (int i = 0; i < 16; i++) gold[i] <= '0;
            end
        end else if (m_wb) begin
            gold[m_addr[3:0]] <= m_word;
            m_wb <= 1'b0;
        end else if (cpu_cs && cpu_rw) begin
            if (cpu_mode[1]) begin
                gold[cpu_addr[5:2]] <= cpu_wdata;
            end else begin
                m_wb   <= 1'b1;
                m_addr <= cpu_addr[31:2];
                m_word <= merge(gold[cpu_addr[5:2]], cpu_wdata, cpu_mode, cpu_addr);
            end
        end
    end

    // Per-cycle comparison of DUT outputs against the model
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst cs_o", 32'(mem_cs), 32'd0);
            check("rst rw_o", 32'(mem_rw), 32'd0);
            check("rst busy", 32'(busy), 32'd0);
        end else if (m_wb) begin
            check("wb cs_o", 32'(mem_cs), 32'd1);
            check("wb rw_o", 32'(mem_rw), 32'd1);
            check("wb busy", 32'(busy), 32'd1);
            check("wb addr", {2'b00, mem_addr}, {2'b00, m_addr});
            check("wb data", mem_bus, m_word);
        end else if (cpu_cs) begin
            check("req cs_o", 32'(mem_cs), 32'd1);
            check("req busy", 32'(busy), 32'd0);
            check("req addr", {2'b00, mem_addr}, {2'b00, cpu_addr[31:2]});
            if (!cpu_rw) begin
                check("rd rw_o", 32'(mem_rw), 32'd0);
                check("rd data", cpu_bus, read_lane(gold[cpu_addr[5:2]], cpu_mode, cpu_addr));
            end else if (cpu_mode[1]) begin
                check("wr rw_o", 32'(mem_rw), 32'd1);
                check("wr data", mem_bus, cpu_wdata);
            end else begin
                check("rmw rd rw_o", 32'(mem_rw), 32'd0);
            end
        end else begin
            check("idle cs_o", 32'(mem_cs), 32'd0);
            check("idle busy", 32'(busy), 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic cs, input logic rw, input logic [1:0] mode,
                         input logic [31:0] addr, input logic [31:0] wdata);
        cpu_cs    = cs;
        cpu_rw    = rw;
        cpu_mode  = mode;
        cpu_addr  = addr;
        cpu_wdata = wdata;
    endtask

    logic [7:0] exp_b [0:3];

    initial begin
        exp_b[0] = 8'h12;
        exp_b[1] = 8'hEF;
        exp_b[2] = 8'hCD;
        exp_b[3] = 8'hAB;

        // Reset state
        step();
        step();
        check("reset busy", 32'(busy), 32'd0);
        check("reset cs_o", 32'(mem_cs), 32'd0);
        mem_clr = 1'b0;
        rst_n   = 1'b1;

        // Word write, then word read back
        step();
        drive(1'b1, 1'b1, 2'd2, 32'h8000_0000, 32'h1234_5678);
        @(negedge clk);
        check("ww addr", {2'b00, mem_addr}, 32'h2000_0000);
        check("ww rw_o", 32'(mem_rw), 32'd1);
        check("ww data", mem_bus, 32'h1234_5678);

        step();
        drive(1'b1, 1'b0, 2'd2, 32'h8000_0000, 32'h0);
        @(negedge clk);
        check("wr rd", cpu_bus, 32'h1234_5678);

        // Halfword reads
        step();
        drive(1'b1, 1'b0, 2'd1, 32'h8000_0000, 32'h0);
        @(negedge clk);
        check("hr lo", cpu_bus, 32'h0000_5678);

        step();
        drive(1'b1, 1'b0, 2'd1, 32'h8000_0002, 32'h0);
        @(negedge clk);
        check("hr hi", cpu_bus, 32'h0000_1234);

        // Byte reads at all four offsets, plus mode 3 as a word read
        step();
        drive(1'b1, 1'b1, 2'd2, 32'h8000_0004, 32'hABCD_EF12);
        for (int k = 0; k < 4; k++) begin
            step();
            drive(1'b1, 1'b0, 2'd0, 32'h8000_0004 + 32'(k), 32'h0);
            @(negedge clk);
            check("br lane", cpu_bus, {24'b0, exp_b[k]});
        end

        step();
        drive(1'b1, 1'b0, 2'd3, 32'h8000_0006, 32'h0);
        @(negedge clk);
        check("m3 rd", cpu_bus, 32'hABCD_EF12);

        // Halfword RMW. Inputs change during write-back and must be ignored.
        step();
        drive(1'b1, 1'b1, 2'd1, 32'h8000_0000, 32'h0000_FAAB);
        @(negedge clk);
        check("hw c1 cs", 32'(mem_cs), 32'd1);
        check("hw c1 rw", 32'(mem_rw), 32'd0);
        check("hw c1 busy", 32'(busy), 32'd0);

        step();
        drive(1'b1, 1'b1, 2'd2, 32'h8000_0008, 32'h0000_FAAB);
        @(negedge clk);
        check("hw c2 rw", 32'(mem_rw), 32'd1);
        check("hw c2 data", mem_bus, 32'h1234_FAAB);
        check("hw c2 busy", 32'(busy), 32'd1);
        check("hw c2 addr", {2'b00, mem_addr}, 32'h2000_0000);

        step();
        drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        @(negedge clk);
        check("hw idle busy", 32'(busy), 32'd0);

        step();
        drive(1'b1, 1'b0, 2'd2, 32'h8000_0000, 32'h0);
        @(negedge clk);
        check("hw result", cpu_bus, 32'h1234_FAAB);

        step();
        drive(1'b1, 1'b0, 2'd2, 32'h8000_0008, 32'h0);
        @(negedge clk);
        check("wb ignored", cpu_bus, 32'h0000_0000);

        // Back-to-back byte RMW writes
        step();
        drive(1'b1, 1'b1, 2'd0, 32'h8000_0003, 32'h0000_00CC);
        step();
        step();
        drive(1'b1, 1'b1, 2'd0, 32'h8000_0000, 32'h0000_00DD);
        @(negedge clk);
        check("b2b rd sees", mem_bus, 32'hCC34_FAAB);

        step();
        @(negedge clk);
        check("b2b wb data", mem_bus, 32'hCC34_FADD);

        step();
        drive(1'b1, 1'b0, 2'd2, 32'h8000_0000, 32'h0);
        @(negedge clk);
        check("b2b result", cpu_bus, 32'hCC34_FADD);

        // Reset during write-back aborts it
        step();
        drive(1'b1, 1'b1, 2'd1, 32'h8000_0000, 32'h0000_1111);
        step();
        #1 rst_n = 1'b0;
        #1;
        check("abort cs_o", 32'(mem_cs), 32'd0);
        check("abort rw_o", 32'(mem_rw), 32'd0);
        check("abort busy", 32'(busy), 32'd0);

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);

        step();
        drive(1'b1, 1'b0, 2'd2, 32'h8000_0000, 32'h0);
        @(negedge clk);
        check("abort result", cpu_bus, 32'hCC34_FADD);

        step();
        drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
